// File: rtl/operand_sequencer.sv
// operand_sequencer
//   Captures operand A, operand B and op select S one field at a time from a
//   shared switch bus, one load-button press per field. It holds all three
//   stable for the downstream logic unit and flags when they are complete.
//
//   Optional build macro: DEBOUNCE_EN
//     Defined   - load passes through a 2-flop synchronizer and a counter
//                 filter before press detection (DEBOUNCE_CYCLES stable samples).
//     Undefined - raw load feeds press detection; DEBOUNCE_CYCLES is unused.
//
//   state | meaning
//   ------+---------------------------------------------
//   00    | WAIT_A  - waiting for press to capture A
//   01    | WAIT_B  - waiting for press to capture B
//   10    | WAIT_OP - waiting for press to capture S
//   11    | READY   - A, B, S loaded; valid high
module operand_sequencer #(
    parameter int NUM_BITS        = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] din,
    input  logic                load,
    input  logic                clear,
    output logic [NUM_BITS-1:0] A,
    output logic [NUM_BITS-1:0] B,
    output logic [2:0]          S,
    output logic                valid,
    output logic                op_err,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        ST_WAIT_A  = 2'b00,
        ST_WAIT_B  = 2'b01,
        ST_WAIT_OP = 2'b10,
        ST_READY   = 2'b11
    } state_t;

    state_t     state_q;
    logic       load_lvl;
    logic       load_q;
    logic       press;
    logic [2:0] s_in;

    // Reject configurations that cannot work before anything is built.
    if (NUM_BITS < 1) begin : g_bad_width
        $error("operand_sequencer: NUM_BITS must be at least 1");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("operand_sequencer: DEBOUNCE_CYCLES must be at least 1");
    end

    // The op select is always 3 bits: narrow buses zero-extend, wide ones drop the top.
    if (NUM_BITS >= 3) begin : g_s_wide
        assign s_in = din[2:0];
    end else begin : g_s_narrow
        assign s_in = {{(3-NUM_BITS){1'b0}}, din};
    end

`ifdef DEBOUNCE_EN
    localparam int            CW     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] db_cnt;
    logic          load_filt;

    // Synchronize the button, then accept a new level only after it has been
    // seen DEBOUNCE_CYCLES times in a row; any return to the old level reloads.
    // Everything resets high so a button held through reset is not a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            db_cnt    <= RELOAD;
            load_filt <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], load};
            if (sync_q[1] == load_filt) begin
                db_cnt <= RELOAD;
            end else if (db_cnt == '0) begin
                load_filt <= sync_q[1];
                db_cnt    <= RELOAD;
            end else begin
                db_cnt <= db_cnt - 1'b1;
            end
        end
    end

    assign load_lvl = load_filt;
`else
    assign load_lvl = load;
`endif

    assign press = load_lvl & ~load_q;
    assign state = state_q;

    // Field-capture sequencer; clear wins over a same-cycle press, and load_q
    // keeps tracking so that press is consumed rather than deferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WAIT_A;
            A       <= '0;
            B       <= '0;
            S       <= '0;
            valid   <= 1'b0;
            op_err  <= 1'b0;
            load_q  <= 1'b1;
        end else begin
            load_q <= load_lvl;
            if (clear) begin
                state_q <= ST_WAIT_A;
                A       <= '0;
                B       <= '0;
                S       <= '0;
                valid   <= 1'b0;
                op_err  <= 1'b0;
            end else if (press) begin
                case (state_q)
                    ST_WAIT_A: begin
                        A       <= din;
                        state_q <= ST_WAIT_B;
                    end
                    ST_WAIT_B: begin
                        B       <= din;
                        state_q <= ST_WAIT_OP;
                    end
                    ST_WAIT_OP: begin
                        S       <= s_in;
                        valid   <= 1'b1;
                        op_err  <= (s_in > 3'd4);
                        state_q <= ST_READY;
                    end
                    default: begin
                        valid   <= 1'b0;
                        op_err  <= 1'b0;
                        state_q <= ST_WAIT_A;
                    end
                endcase
            end
        end
    end

endmodule
